// File: rtl/gbf_pkg.sv
// Shared definitions for the GBF stream reader: size defaults, address-width
// derivation and the controller state encoding.
package gbf_pkg;

    localparam int GBF_WIDTH  = 32;
    localparam int GBF_HEIGHT = 48;

    // Address width needed to index a buffer of the given depth (never below 1).
    function automatic int gbf_aw(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } gbf_state_t;

endpackage

// File: rtl/gbf_fifo2.sv
// Two-entry register FIFO used as the output skid buffer of the stream reader.
// Read data comes straight from the entry registers, so the consumer side sees
// no combinational path from the pop request.
module gbf_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;
    logic       w_push_ok;
    logic       w_pop_ok;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_pop_ok  = i_pop && (r_count != 2'd0);
    assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);
    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [WIDTH-1:0] r_entry;

            // Capture write data into this slot when the write pointer selects it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_entry <= '0;
                end else if (w_push_ok && (r_wptr == 1'(gi))) begin
                    r_entry <= i_wdata;
                end
            end
        end
    endgenerate

    assign o_rdata = r_rptr ? g_entry[1].r_entry : g_entry[0].r_entry;

    // Advance pointers and track occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop_ok) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gbf_stream_reader.sv
// Burst reader: streams a run of consecutive buffer words (address wraps at
// HEIGHT) out through a ready/valid interface behind a two-entry FIFO.
// Optional macro GBF_RD_CLEAR_EN: each fetched word is zeroed in the buffer
// at the same edge that captures it.
module gbf_stream_reader
    import gbf_pkg::*;
#(
    parameter  int WIDTH  = GBF_WIDTH,
    parameter  int HEIGHT = GBF_HEIGHT,
    localparam int AW     = gbf_aw(HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0] mem_q,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [AW:0]   LEN_MAX   = (AW + 1)'(HEIGHT);
    localparam logic [AW:0]   LEN_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(HEIGHT - 1);

    gbf_state_t       r_state;
    gbf_state_t       w_state_next;
    logic [AW-1:0]    r_addr;
    logic [AW:0]      r_remaining;
    logic             r_done;
    logic             w_done_next;
    logic             w_fetch;
    logic             w_accept;
    logic [AW:0]      w_len_eff;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_last_word;

    assign w_len_eff   = (len > LEN_MAX) ? LEN_MAX : len;
    assign out_valid   = ~w_fifo_empty;
    assign w_pop       = out_valid & out_ready;
    assign w_last_word = ~w_fifo_empty & ~w_fifo_full;

    gbf_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fetch),
        .i_wdata (mem_q),
        .i_pop   (w_pop),
        .o_rdata (out_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Next-state, fetch-enable and done decision for the burst controller.
    always_comb begin
        w_state_next = r_state;
        w_fetch      = 1'b0;
        w_accept     = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (w_len_eff != '0) begin
                        w_state_next = ST_FETCH;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                // A slot is available if the FIFO has room or its head leaves now.
                w_fetch = ~w_fifo_full | w_pop;
                if (w_fetch && (r_remaining == LEN_ONE)) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish once the only remaining buffered word transfers.
                if (w_pop && w_last_word) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, address/count and done-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            if (w_accept) begin
                r_addr      <= base_addr;
                r_remaining <= w_len_eff;
            end else if (w_fetch) begin
                r_addr      <= (r_addr == ADDR_LAST) ? '0 : r_addr + AW'(1);
                r_remaining <= r_remaining - LEN_ONE;
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign mem_addr = r_addr;

`ifdef GBF_RD_CLEAR_EN
    assign mem_we    = w_fetch;
    assign mem_wdata = '0;
`else
    assign mem_we    = 1'b0;
    assign mem_wdata = '0;
`endif

endmodule

// File: tb/tb_gbf_stream_reader.sv
// Directed testbench for gbf_stream_reader with a behavioural buffer model
// preloaded with word i = 0x100 + i.
module tb_gbf_stream_reader;

    localparam int WIDTH  = 32;
    localparam int HEIGHT = 48;
    localparam int AW     = $clog2(HEIGHT);

`ifdef GBF_RD_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             preload;
    logic             out_ready;
    logic [AW-1:0]    base_addr;
    logic [AW-1:0]    mem_addr;
    logic [AW:0]      len;
    logic             busy;
    logic             done;
    logic             mem_we;
    logic             out_valid;
    logic [WIDTH-1:0] mem_q;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] buf_mem [HEIGHT];
    logic [WIDTH-1:0] exp_q [$];
    int               n_cmp = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    gbf_stream_reader #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_q     (mem_q),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign mem_q = buf_mem[mem_addr];

    // Buffer model: bulk preload, otherwise honour the DUT write port.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < HEIGHT; i++) begin
                buf_mem[i] <= 32'h100 + i;
            end
        end else if (mem_we) begin
            buf_mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic reload();
        preload = 1'b1;
        step();
        preload = 1'b0;
    endtask

    // Watch the stream until done; mode 0 = ready always high, mode 1 = ready 1,0,0,...
    // In mode 1 a start with a different burst is pulsed mid-stream.
    task automatic check_stream(input string tag, input int mode);
        int idx  = 0;
        int cyc  = 0;
        bit seen = 1'b0;
        while (!seen && cyc < 200) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (mode == 1) begin
                start     = (cyc == 4);
                base_addr = AW'(20);
                len       = (AW + 1)'(3);
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                if (out_valid && out_ready) begin
                    if (idx < exp_q.size()) begin
                        chk({tag, "_data"}, out_data, exp_q[idx]);
                    end else begin
                        chk({tag, "_extra"}, 32'(idx), 32'(exp_q.size()));
                    end
                    idx++;
                end
                step();
                cyc++;
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_count"}, 32'(idx), 32'(exp_q.size()));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        preload   = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        base_addr = '0;
        len       = '0;
        step();
        step();
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  out_data, 32'd0);
        chk("rst_addr",  32'(mem_addr), 32'd0);
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst     = 1'b0;
        preload = 1'b0;
        step();

        // Burst base=0 len=4, exact cycle timing.
        base_addr = AW'(0);
        len       = (AW + 1)'(4);
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("b1_busy_n1",  32'(busy), 32'd1);
        chk("b1_valid_n1", 32'(out_valid), 32'd0);
        chk("b1_addr_n1",  32'(mem_addr), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b1_valid", 32'(out_valid), 32'd1);
            chk("b1_data",  out_data, 32'h100 + i);
            chk("b1_nodone", 32'(done), 32'd0);
        end
        step();
        chk("b1_done",     32'(done), 32'd1);
        chk("b1_busy_end", 32'(busy), 32'd0);
        chk("b1_valid_end", 32'(out_valid), 32'd0);
        step();
        chk("b1_done_once", 32'(done), 32'd0);

        // Wrap-around burst base=46 len=4.
        reload();
        base_addr = AW'(46);
        len       = (AW + 1)'(4);
        start     = 1'b1;
        step();
        start = 1'b0;
        exp_q = '{32'h12E, 32'h12F, 32'h100, 32'h101};
        check_stream("wrap", 0);

        // Zero-length burst.
        step();
        base_addr = AW'(5);
        len       = '0;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("z_done",  32'(done), 32'd1);
        chk("z_busy",  32'(busy), 32'd0);
        chk("z_valid", 32'(out_valid), 32'd0);
        step();
        chk("z_done_once", 32'(done), 32'd0);
        chk("z_busy2",     32'(busy), 32'd0);
        chk("z_valid2",    32'(out_valid), 32'd0);

        // Back-pressure pattern with an ignored start mid-burst.
        reload();
        base_addr = AW'(0);
        len       = (AW + 1)'(6);
        start     = 1'b1;
        step();
        start = 1'b0;
        exp_q = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105};
        check_stream("toggle", 1);
        step();
        chk("toggle_idle_busy",  32'(busy), 32'd0);
        chk("toggle_idle_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a len=8 burst after two transfers.
        reload();
        base_addr = AW'(0);
        len       = (AW + 1)'(8);
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("ra_t0", out_data, 32'h100);
        step();
        chk("ra_t1", out_data, 32'h101);
        step();
        rst = 1'b1;
        #1;
        chk("ra_busy",  32'(busy), 32'd0);
        chk("ra_done",  32'(done), 32'd0);
        chk("ra_valid", 32'(out_valid), 32'd0);
        chk("ra_data",  out_data, 32'd0);
        chk("ra_addr",  32'(mem_addr), 32'd0);
        chk("ra_we",    32'(mem_we), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ra_nodone",  32'(done), 32'd0);
            chk("ra_novalid", 32'(out_valid), 32'd0);
        end
        reload();
        base_addr = AW'(10);
        len       = (AW + 1)'(3);
        start     = 1'b1;
        step();
        start = 1'b0;
        exp_q = '{32'h10A, 32'h10B, 32'h10C};
        check_stream("after_rst", 0);

        // Two identical bursts base=3 len=2; second sees cleared words when enabled.
        reload();
        base_addr = AW'(3);
        len       = (AW + 1)'(2);
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("clr_we",    32'(mem_we), 32'(CLR));
        chk("clr_wdata", mem_wdata, 32'd0);
        exp_q = '{32'h103, 32'h104};
        check_stream("clr1", 0);
        start = 1'b1;
        step();
        start = 1'b0;
        if (CLR) begin
            exp_q = '{32'h0, 32'h0};
        end else begin
            exp_q = '{32'h103, 32'h104};
        end
        check_stream("clr2", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
